// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } addr_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_ALL  = 4'b1111;

  // Unsigned sizes exist only for loads; 011/110/111 are never legal.
  function automatic logic mode_legal(input logic [2:0] mode, input logic is_store);
    case (mode)
      3'b000, 3'b001, 3'b010: mode_legal = 1'b1;
      3'b100, 3'b101:         mode_legal = ~is_store;
      default:                mode_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store shift, byte enables, alignment check,
// and load lane select with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       mode,
  input  logic [1:0]       addr_lo,
  input  logic             is_store,
  input  logic [WIDTH-1:0] wdata,
  output logic [3:0]       be,
  output logic [WIDTH-1:0] wdata_sh,
  output logic             legal,
  input  logic [2:0]       ld_mode,
  input  logic [1:0]       ld_addr_lo,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] rdata_ext
);

  addr_mode_e st_m;
  addr_mode_e ld_m;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign st_m = addr_mode_e'(mode);
  assign ld_m = addr_mode_e'(ld_mode);

  // Request side: narrow data is replicated so every selected lane carries it.
  always_comb begin
    be       = BE_NONE;
    wdata_sh = '0;
    legal    = mode_legal(mode, is_store);
    case (st_m)
      LB, LBU: begin
        be       = 4'(4'b0001 << addr_lo);
        wdata_sh = WIDTH'({4{wdata[7:0]}});
      end
      LH, LHU: begin
        be       = addr_lo[1] ? BE_HI : BE_LO;
        wdata_sh = WIDTH'({2{wdata[15:0]}});
        if (addr_lo[0]) legal = 1'b0;
      end
      LW: begin
        be       = BE_ALL;
        wdata_sh = wdata;
        if (addr_lo != 2'b00) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  // Response side uses the mode and offset captured with the request.
  always_comb begin
    byte_sel  = rdata[{ld_addr_lo, 3'b000} +: 8];
    half_sel  = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    rdata_ext = '0;
    case (ld_m)
      LB:      rdata_ext = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      LBU:     rdata_ext = {{(WIDTH-8){1'b0}}, byte_sel};
      LH:      rdata_ext = {{(WIDTH-16){half_sel[15]}}, half_sel};
      LHU:     rdata_ext = {{(WIDTH-16){1'b0}}, half_sel};
      LW:      rdata_ext = rdata;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM load/store controls into a
// valid/ready word request and stalls until it completes.
// Optional BUSY watchdog enabled by defining LSU_TIMEOUT_EN.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRead_M,
  input  logic             MemWrite_M,
  input  logic [2:0]       AddrMode_M,
  input  logic [WIDTH-1:0] ALUResult_M,
  input  logic [WIDTH-1:0] WriteData_M,
  output logic [WIDTH-1:0] ReadData_M,
  output logic             Stall_M,
  output logic             Misaligned_M,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);

  lsu_state_e       state;
  logic [2:0]       mode_q;
  logic [1:0]       addr_lo_q;
  logic             ld_q;
  logic             access;
  logic             legal;
  logic [3:0]       be_c;
  logic [WIDTH-1:0] wdata_c;
  logic [WIDTH-1:0] rdata_ext;
  logic             tmo_hit;

  assign access = MemRead_M | MemWrite_M;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .mode       (AddrMode_M),
    .addr_lo    (ALUResult_M[1:0]),
    .is_store   (MemWrite_M),
    .wdata      (WriteData_M),
    .be         (be_c),
    .wdata_sh   (wdata_c),
    .legal      (legal),
    .ld_mode    (mode_q),
    .ld_addr_lo (addr_lo_q),
    .rdata      (mem_rdata),
    .rdata_ext  (rdata_ext)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Counts unanswered BUSY cycles; any non-BUSY cycle clears it before entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == BUSY && !mem_ready) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  // Stall must be visible in the same IDLE cycle the access is presented.
  always_comb begin
    Stall_M = 1'b0;
    case (state)
      IDLE:    Stall_M = access & legal;
      BUSY:    Stall_M = 1'b1;
      default: Stall_M = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= BE_NONE;
      ReadData_M   <= '0;
      Misaligned_M <= 1'b0;
      mode_q       <= 3'b000;
      addr_lo_q    <= 2'b00;
      ld_q         <= 1'b0;
    end else begin
      Misaligned_M <= 1'b0;
      case (state)
        IDLE: begin
          if (access && legal) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWrite_M;
            mem_addr  <= {ALUResult_M[WIDTH-1:2], 2'b00};
            mem_wdata <= wdata_c;
            mem_be    <= be_c;
            mode_q    <= AddrMode_M;
            addr_lo_q <= ALUResult_M[1:0];
            ld_q      <= ~MemWrite_M;
            state     <= BUSY;
          end else if (access) begin
            Misaligned_M <= 1'b1;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_req    <= 1'b0;
            ReadData_M <= ld_q ? rdata_ext : '0;
            state      <= DONE;
          end else if (tmo_hit) begin
            // Abandoned access reports through the shared fault flag.
            mem_req      <= 1'b0;
            ReadData_M   <= '0;
            Misaligned_M <= 1'b1;
            state        <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: request fields and load results are
// queued when an access is driven and compared when the DUT produces them.
module tb_mem_stage_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_M, MemWrite_M;
  logic [2:0]  AddrMode_M;
  logic [31:0] ALUResult_M, WriteData_M;
  logic [31:0] ReadData_M;
  logic        Stall_M, Misaligned_M;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  mem_stage_lsu #(.WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M), .AddrMode_M(AddrMode_M),
    .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M),
    .ReadData_M(ReadData_M), .Stall_M(Stall_M), .Misaligned_M(Misaligned_M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] rd;
    logic        fault;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;

  int          ready_delay = 0;
  int          wait_cnt    = 0;
  logic        idle_ready  = 1'b0;
  logic [31:0] rword_v     = '0;
  logic        prev_req    = 1'b0;
  logic [68:0] snap;
  logic [2:0]  modes [5] = '{LB, LH, LW, LBU, LHU};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_be(input logic [2:0] mode, input logic [1:0] a);
    case (mode[1:0])
      2'b00:   return 4'(4'b0001 << a);
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Expected byte in each enabled lane for a store.
  function automatic logic [31:0] m_lanes(input logic [2:0] mode, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        case (mode[1:0])
          2'b00:   r[8*i +: 8] = wd[7:0];
          2'b01:   r[8*i +: 8] = wd[8*(i%2) +: 8];
          default: r[8*i +: 8] = wd[8*i +: 8];
        endcase
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] mode, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * a);
    case (mode)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  // Memory model: answers after ready_delay BUSY cycles.
  always @(negedge clk) begin
    mem_rdata = rword_v;
    if (mem_req && !rst) begin
      mem_ready = (wait_cnt == ready_delay);
      wait_cnt++;
    end else begin
      mem_ready = idle_ready;
      wait_cnt  = 0;
    end
  end

  // Scoreboard monitor: request issue, request stability, completion.
  always @(negedge clk) begin
    req_t r;
    rsp_t s;
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      if (mem_req && !prev_req) begin
        if (req_q.size() == 0) begin
          check("req_unexpected", 128'(1), 128'(0));
        end else begin
          r = req_q.pop_front();
          check("req_addr", 128'(mem_addr), 128'(r.addr));
          check("req_we",   128'(mem_we),   128'(r.we));
          check("req_be",   128'(mem_be),   128'(r.be));
          if (r.we) check("req_wdata", 128'(mem_wdata & m_mask(r.be)), 128'(r.wdata));
        end
        snap = {mem_addr, mem_we, mem_be, mem_wdata};
      end else if (mem_req && prev_req) begin
        check("req_stable", 128'({mem_addr, mem_we, mem_be, mem_wdata}), 128'(snap));
      end else if (!mem_req && prev_req) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 128'(1), 128'(0));
        end else begin
          s = rsp_q.pop_front();
          check("done_rdata", 128'(ReadData_M),   128'(s.rd));
          check("done_fault", 128'(Misaligned_M), 128'(s.fault));
          check("done_stall", 128'(Stall_M),      128'(0));
        end
      end
      prev_req = mem_req;
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [2:0] mode,
                       input logic [31:0] addr, input logic [31:0] wd);
    MemRead_M   = rd;
    MemWrite_M  = wr;
    AddrMode_M  = mode;
    ALUResult_M = addr;
    WriteData_M = wd;
  endtask

  task automatic idle_inputs();
    MemRead_M  = 1'b0;
    MemWrite_M = 1'b0;
  endtask

  // Legal access; entered and left just after a posedge.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] mode,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rword, input int delay, input int exp_stall,
                           input logic [31:0] exp_rd, input logic exp_fault);
    req_t r;
    rsp_t s;
    int   stalls;
    r.addr  = {addr[31:2], 2'b00};
    r.we    = wr;
    r.be    = m_be(mode, addr[1:0]);
    r.wdata = m_lanes(mode, wd, r.be);
    req_q.push_back(r);
    s.rd    = exp_rd;
    s.fault = exp_fault;
    rsp_q.push_back(s);
    rword_v     = rword;
    ready_delay = delay;
    drive(rd, wr, mode, addr, wd);
    stalls = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!Stall_M) break;
      stalls++;
      @(posedge clk); #1;
    end
    idle_inputs();
    check("stall_cycles", 128'(stalls), 128'(exp_stall));
    @(posedge clk); #1;
  endtask

  task automatic do_bad(input logic rd, input logic wr, input logic [2:0] mode, input logic [31:0] addr);
    drive(rd, wr, mode, addr, 32'h5A5A5A5A);
    @(negedge clk);
    check("bad_stall", 128'(Stall_M), 128'(0));
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("bad_flag", 128'(Misaligned_M), 128'(1));
    check("bad_req",  128'(mem_req),      128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("bad_flag_clear", 128'(Misaligned_M), 128'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  md;
    logic [31:0] a, w;
    logic        wr;
    int          dl;
    req_t        r;
    logic [31:0] rd_before;

    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req",   128'(mem_req),      128'(0));
    check("rst_we",    128'(mem_we),       128'(0));
    check("rst_addr",  128'(mem_addr),     128'(0));
    check("rst_wdata", 128'(mem_wdata),    128'(0));
    check("rst_be",    128'(mem_be),       128'(0));
    check("rst_rdata", 128'(ReadData_M),   128'(0));
    check("rst_fault", 128'(Misaligned_M), 128'(0));
    check("rst_stall", 128'(Stall_M),      128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    do_access(1, 0, LW,  32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 32'hDEADBEEF, 0);
    do_access(1, 0, LB,  32'h103, 32'h0, 32'h80123456, 0, 2, 32'hFFFFFF80, 0);
    do_access(1, 0, LBU, 32'h103, 32'h0, 32'h80123456, 1, 3, 32'h00000080, 0);
    do_access(0, 1, LH,  32'h202, 32'h1234ABCD, 32'h0, 3, 5, 32'h0, 0);
    do_access(1, 0, LH,  32'h102, 32'h0, 32'h8001CAFE, 0, 2, 32'hFFFF8001, 0);
    do_access(1, 0, LHU, 32'h000, 32'h0, 32'h1234F00F, 2, 4, 32'h0000F00F, 0);
    do_access(0, 1, LB,  32'h001, 32'hFFFFFFA5, 32'h0, 0, 2, 32'h0, 0);
    do_access(0, 1, LW,  32'h010, 32'hCAFEF00D, 32'h0, 1, 3, 32'h0, 0);
    do_access(1, 0, LW,  32'h104, 32'h0, 32'h13572468, 0, 2, 32'h13572468, 0);
    do_access(1, 1, LW,  32'h020, 32'h0BADF00D, 32'h77777777, 0, 2, 32'h0, 0);

    do_bad(1, 0, LW,     32'h101);
    do_bad(1, 0, LH,     32'h103);
    do_bad(0, 1, LBU,    32'h100);
    do_bad(1, 0, 3'b011, 32'h100);
    do_bad(0, 1, LW,     32'h102);

    for (int i = 0; i < 10; i++) begin
      wr = 1'($urandom_range(0, 1));
      md = wr ? modes[$urandom_range(0, 2)] : modes[$urandom_range(0, 4)];
      a  = $urandom;
      w  = $urandom;
      if (md[1:0] == 2'b01) a[0] = 1'b0;
      if (md[1:0] == 2'b10) a[1:0] = 2'b00;
      dl = $urandom_range(0, 3);
      do_access(~wr, wr, md, a, w, w, dl, dl + 2, wr ? 32'h0 : m_load(md, a[1:0], w), 0);
    end

    // mem_ready outside BUSY must change nothing.
    do_access(1, 0, LW, 32'h108, 32'h0, 32'h2468ACE0, 0, 2, 32'h2468ACE0, 0);
    rword_v    = 32'h11112222;
    idle_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_ready_req",   128'(mem_req),    128'(0));
    check("idle_ready_rdata", 128'(ReadData_M), 128'(32'h2468ACE0));
    @(posedge clk); #1;
    idle_ready = 1'b0;

    // Reset in the second BUSY cycle abandons the request.
    r.addr = 32'h40; r.we = 1'b0; r.be = 4'hF; r.wdata = '0;
    req_q.push_back(r);
    ready_delay = 20;
    rd_before   = ReadData_M;
    drive(1, 0, LW, 32'h40, 32'h0);
    @(negedge clk);
    check("rstbusy_stall0", 128'(Stall_M), 128'(1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstbusy_prior_rdata", 128'(rd_before), 128'(32'h2468ACE0));
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    @(negedge clk);
    check("rstbusy_req",   128'(mem_req),    128'(0));
    check("rstbusy_stall", 128'(Stall_M),    128'(0));
    check("rstbusy_rdata", 128'(ReadData_M), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    do_access(1, 0, LW, 32'h104, 32'h0, 32'hA5A5A5A5, 0, 2, 32'hA5A5A5A5, 0);
`ifdef LSU_TIMEOUT_EN
    do_access(1, 0, LW, 32'h300, 32'h0, 32'h11111111, 1000, 5, 32'h0, 1);
`else
    do_access(1, 0, LW, 32'h300, 32'h0, 32'h11111111, 10, 12, 32'h11111111, 0);
`endif

    repeat (2) @(posedge clk);
    check("req_q_empty", 128'(req_q.size()), 128'(0));
    check("rsp_q_empty", 128'(rsp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
